// File: rtl/scan_pkg.sv
// Shared types and default timing constants for the multiplexed digit scanner.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  localparam int unsigned C_DIV_DEFAULT   = 1000;
  localparam int unsigned C_BLANK_DEFAULT = 16;

endpackage

// File: rtl/scan_next_idx.sv
// Finds the next set mask bit above cur_idx, wrapping modulo 8.
// With cur_idx = 7 the result is the lowest set bit of the mask.
module scan_next_idx (
  input  logic [7:0] mask,
  input  logic [2:0] cur_idx,
  output logic [2:0] next_idx,
  output logic       valid
);

  logic [2:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest set bit wins; offset 8 is cur_idx itself.
  always_comb begin
    next_idx = 3'd0;
    valid    = 1'b0;
    idx_s    = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx_s = cur_idx + 3'(k);
      if (mask[idx_s]) begin
        next_idx = idx_s;
        valid    = 1'b1;
      end else begin
        valid    = valid;
      end
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner: SHOW/BLANK dwell per enabled digit, with an 8x4 digit bank.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned P_DIV   = C_DIV_DEFAULT,
  parameter int unsigned P_BLANK = C_BLANK_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_mask,
  input  logic       i_polarity,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  output logic [2:0] o_sel,
  output logic       o_opt,
  output logic       o_blank,
  output logic [3:0] o_digit,
  output logic       o_frame
);

  localparam int DIV_W = $clog2(P_DIV);
  localparam int BLK_W = (P_BLANK > 0) ? $clog2(P_BLANK + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(P_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'((P_BLANK > 0) ? (P_BLANK - 1) : 0);
  localparam bit               HAS_BLANK = (P_BLANK > 0);

  scan_state_t      state_r;
  logic [2:0]       sel_r;
  logic             opt_r;
  logic             blank_r;
  logic             frame_r;
  logic [DIV_W-1:0] dwell_cnt_r;
  logic [BLK_W-1:0] blank_cnt_r;
  logic [3:0]       bank_r [8];

  logic [2:0] next_idx_s;
  logic       next_valid_s;
  logic [2:0] low_idx_s;
  logic       low_valid_s;
  logic       adv_s;

  scan_next_idx u_next (
    .mask     (i_mask),
    .cur_idx  (sel_r),
    .next_idx (next_idx_s),
    .valid    (next_valid_s)
  );

  scan_next_idx u_low (
    .mask     (i_mask),
    .cur_idx  (3'd7),
    .next_idx (low_idx_s),
    .valid    (low_valid_s)
  );

  // An advance ends the current digit: after BLANK, or straight out of SHOW when there is no gap.
  always_comb begin
    if (state_r == ST_BLANK) begin
      adv_s = (blank_cnt_r == BLK_LAST);
    end else if (state_r == ST_SHOW) begin
      adv_s = !HAS_BLANK && (dwell_cnt_r == DIV_LAST);
    end else begin
      adv_s = 1'b0;
    end
  end

  // Scan sequencer with registered select, blank, frame and polarity outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= 3'd0;
      opt_r       <= 1'b0;
      blank_r     <= 1'b1;
      frame_r     <= 1'b0;
      dwell_cnt_r <= '0;
      blank_cnt_r <= '0;
    end else begin
      opt_r   <= i_polarity;
      frame_r <= 1'b0;
      if (!i_en || (adv_s && !next_valid_s)) begin
        state_r     <= ST_IDLE;
        sel_r       <= 3'd0;
        blank_r     <= 1'b1;
        dwell_cnt_r <= '0;
        blank_cnt_r <= '0;
      end else if (adv_s) begin
        state_r     <= ST_SHOW;
        sel_r       <= next_idx_s;
        blank_r     <= 1'b0;
        frame_r     <= (next_idx_s == low_idx_s);
        dwell_cnt_r <= '0;
        blank_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (low_valid_s) begin
              state_r <= ST_SHOW;
              sel_r   <= low_idx_s;
              blank_r <= 1'b0;
              frame_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              sel_r   <= 3'd0;
              blank_r <= 1'b1;
            end
            dwell_cnt_r <= '0;
            blank_cnt_r <= '0;
          end
          ST_SHOW: begin
            if (dwell_cnt_r == DIV_LAST) begin
              state_r     <= ST_BLANK;
              blank_r     <= 1'b1;
              dwell_cnt_r <= '0;
              blank_cnt_r <= '0;
            end else begin
              dwell_cnt_r <= dwell_cnt_r + DIV_W'(1);
            end
          end
          ST_BLANK: begin
            blank_cnt_r <= blank_cnt_r + BLK_W'(1);
          end
          default: begin
            state_r     <= ST_IDLE;
            sel_r       <= 3'd0;
            blank_r     <= 1'b1;
            dwell_cnt_r <= '0;
            blank_cnt_r <= '0;
          end
        endcase
      end
    end
  end

  // Digit bank write port; reset wins over a coincident write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        bank_r[i] <= 4'd0;
      end
    end else if (i_wr_en) begin
      bank_r[i_wr_addr] <= i_wr_data;
    end else begin
      bank_r[i_wr_addr] <= bank_r[i_wr_addr];
    end
  end

  assign o_sel   = sel_r;
  assign o_opt   = opt_r;
  assign o_blank = blank_r;
  assign o_frame = frame_r;
  assign o_digit = bank_r[sel_r];

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter P_DIV, default 1000: SHOW dwell per digit in i_clk cycles, legal range >= 2.
REQ-002 SHALL have parameter P_BLANK, default 16: BLANK gap between digits in i_clk cycles, legal range >= 0.
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_en  in  1  scan enable.
REQ-006 SHALL have port i_mask  in  8  per-digit enable; bit n enables digit n.
REQ-007 SHALL have port i_polarity  in  1  requested select polarity.
REQ-008 SHALL have ports i_wr_en (in, 1), i_wr_addr (in, 3) and i_wr_data (in, 4): the digit-bank write port.
REQ-009 SHALL have port o_sel  out  3  current digit index; feeds the 3-to-8 decoder select input.
REQ-010 SHALL have port o_opt  out  1  registered i_polarity; feeds the decoder polarity input.
REQ-011 SHALL have port o_blank  out  1  high means the consumer gates all digits off.
REQ-012 SHALL have port o_digit  out  4  bank contents at index o_sel.
REQ-013 SHALL have port o_frame  out  1  one-cycle frame-start pulse.

Function
REQ-014 SHALL implement states IDLE, SHOW and BLANK.
REQ-015 In IDLE, with i_en=1 and i_mask!=0, SHALL enter SHOW at the lowest set mask index on the next edge; otherwise it SHALL remain in IDLE.
REQ-016 SHOW SHALL last exactly P_DIV cycles, with o_blank=0 throughout and o_sel held constant.
REQ-017 After SHOW, SHALL enter BLANK for exactly P_BLANK cycles with o_blank=1 and o_sel unchanged; if P_BLANK=0, BLANK SHALL be skipped.
REQ-018 On leaving BLANK, or leaving SHOW when P_BLANK=0, SHALL load o_sel with the next set mask bit above o_sel, searching modulo 8, and re-enter SHOW.
REQ-019 o_frame SHALL be 1 for exactly the first cycle of each SHOW whose o_sel equals the lowest set mask index; with one enabled digit it therefore pulses every dwell.
REQ-020 SHALL sample i_mask only at IDLE exit and at each advance; clearing the current digit's bit mid-dwell SHALL NOT shorten that dwell.
REQ-021 If i_mask is 0 at an advance, SHALL go to IDLE.
REQ-022 i_en=0 in any state SHALL force IDLE on the next edge, aborting the dwell; in IDLE o_blank=1, o_sel=0 and the dwell counter is cleared.
REQ-023 o_opt SHALL follow i_polarity with exactly one cycle of latency in every state.
REQ-024 SHALL hold an 8x4 bank; a write on an edge with i_wr_en=1 SHALL update bank[i_wr_addr].
REQ-025 o_digit SHALL be a combinational read of bank[o_sel]; a write to the displayed index SHALL be visible in the cycle after the write edge.
REQ-026 Simultaneous write and advance SHALL both take effect; no write is dropped.
REQ-027 The dwell counter SHALL be $clog2(P_DIV) bits wide; the blank counter SHALL be max(1,$clog2(P_BLANK+1)) bits wide; neither SHALL wrap unchecked.

Reset
REQ-028 While i_rst=1 at an edge, SHALL force state IDLE, o_sel=0, o_opt=0, o_blank=1, o_frame=0, both counters 0 and all bank entries 0.
REQ-029 i_rst SHALL take priority over i_en and over writes; a reset asserted mid-SHOW SHALL give IDLE on the next edge.

Structure
REQ-030 Package scan_pkg SHALL hold the state enum and the P_DIV/P_BLANK default constants.
REQ-031 The next-index search SHALL be a single combinational sub-module, scan_next_idx (inputs: mask, current index; outputs: next index, valid).

Verification (P_DIV=4, P_BLANK=2)
REQ-032 Reset release, i_en=1, i_mask=8'hFF: o_sel steps 0..7 every 6 cycles, o_blank high 2 of every 6, o_frame once per 48 cycles.
REQ-033 i_mask=8'b1000_0100: o_sel alternates 2,7,2,...; o_frame pulses only on entry to digit 2.
REQ-034 i_mask=8'h10: o_sel stays 4; o_frame pulses every 6 cycles.
REQ-035 Write 4'hA to the displayed address mid-SHOW: o_digit=4'hA the next cycle; the dwell length is unchanged.
REQ-036 i_en dropped in cycle 2 of SHOW: IDLE next cycle, o_blank=1, o_sel=0; when i_en returns, the scan restarts at the lowest enabled digit with o_frame=1.
REQ-037 i_polarity toggled: o_opt follows one cycle later; mask set to 0 at an advance: IDLE entered, o_blank stays 1.
